// File: rtl/xor_rr_scheduler_pkg.sv
// xor_rr_scheduler_pkg: default sizing and id-width helper for the shared XOR scheduler
package xor_rr_scheduler_pkg;
   localparam int DEF_N_REQ = 4;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 16;
   function automatic int id_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/xor_rr_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter
   import xor_rr_scheduler_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   localparam int ID_W = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   input  logic             en,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_idx,
   output logic             any
);
   always_comb begin
      grant_idx = '0;
      any = 1'b0;
      // Walk offsets high to low so the smallest offset from ptr wins.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N_REQ]) begin
            grant_idx = ID_W'((int'(ptr) + i) % N_REQ);
            any = 1'b1;
         end
      end
      grant = '0;
      if (en && any) grant[grant_idx] = 1'b1;
   end
endmodule

// File: rtl/xor_rr_scheduler.sv
// xor_rr_scheduler: shares one registered XOR unit among N_REQ round-robin requesters
module xor_rr_scheduler
   import xor_rr_scheduler_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W,
   localparam int ID_W = id_w(N_REQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WIDTH-1:0]       rsp_data,
   output logic [ID_W-1:0]        rsp_id,
   output logic [CNT_W-1:0]       txn_count
);
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] grant_idx;
   logic            any;
   logic            can_accept;
   logic            accept;
   logic [WIDTH-1:0] xor_sel;
   assign can_accept = !rsp_valid || rsp_ready;
   assign accept = any && can_accept && !reset;
   assign xor_sel = req_a[grant_idx*WIDTH +: WIDTH] ^ req_b[grant_idx*WIDTH +: WIDTH];
   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req(req_valid),
      .ptr(ptr),
      .en(can_accept && !reset),
      .grant(req_ready),
      .grant_idx(grant_idx),
      .any(any)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
         rsp_valid <= 1'b0;
         rsp_data <= '0;
         rsp_id <= '0;
         txn_count <= '0;
      end else if (accept) begin
         ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
         rsp_valid <= 1'b1;
         rsp_data <= xor_sel;
         rsp_id <= grant_idx;
         txn_count <= txn_count + CNT_W'(1);
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_xor_rr_scheduler.sv
// tb_xor_rr_scheduler: directed vectors for the shared XOR scheduler, plus a 4-bit counter instance for wrap
module tb_xor_rr_scheduler;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready, w_req_ready;
   logic [31:0] req_a, req_b;
   logic        rsp_valid, w_rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data, w_rsp_data;
   logic [1:0]  rsp_id, w_rsp_id;
   logic [15:0] txn_count;
   logic [3:0]  w_txn_count;
   int vectors = 0;
   int errors = 0;
   always #5 clk = ~clk;
   xor_rr_scheduler u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .txn_count(txn_count)
   );
   xor_rr_scheduler #(.CNT_W(4)) u_wrap (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(w_req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(w_rsp_data), .rsp_id(w_rsp_id), .txn_count(w_txn_count)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   // a^b per requester: 0->11, 1->0F, 2->AA, 3->C3
   initial begin
      req_a = {8'h3C, 8'hA5, 8'h5A, 8'h01};
      req_b = {8'hFF, 8'h0F, 8'h55, 8'h10};
      reset = 1'b1;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_ready", 32'(req_ready), 0);
         check("rst_valid", 32'(rsp_valid), 0);
         check("rst_count", 32'(txn_count), 0);
      end
      check("rst_data", 32'(rsp_data), 0);
      check("rst_id", 32'(rsp_id), 0);
      reset = 1'b0;
      req_valid = 4'b0100;
      #1 check("single_ready", 32'(req_ready), 32'h4);
      tick();
      check("single_valid", 32'(rsp_valid), 1);
      check("single_data", 32'(rsp_data), 32'hAA);
      check("single_id", 32'(rsp_id), 2);
      check("single_count", 32'(txn_count), 1);
      reset = 1'b1;
      req_valid = 4'h0;
      tick();
      reset = 1'b0;
      req_valid = 4'hF;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("fair_id", 32'(rsp_id), i % 4);
         check("fair_valid", 32'(rsp_valid), 1);
      end
      check("fair_count", 32'(txn_count), 8);
      check("fair_data", 32'(rsp_data), 32'hC3);
      rsp_ready = 1'b0;
      #1 check("bp_ready0", 32'(req_ready), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_ready", 32'(req_ready), 0);
         check("bp_valid", 32'(rsp_valid), 1);
         check("bp_data", 32'(rsp_data), 32'hC3);
         check("bp_id", 32'(rsp_id), 3);
      end
      check("bp_count", 32'(txn_count), 8);
      rsp_ready = 1'b1;
      req_valid = 4'b0010;
      #1 check("refill_ready", 32'(req_ready), 32'h2);
      tick();
      check("refill_valid", 32'(rsp_valid), 1);
      check("refill_id", 32'(rsp_id), 1);
      check("refill_data", 32'(rsp_data), 32'h0F);
      check("refill_count", 32'(txn_count), 9);
      rsp_ready = 1'b0;
      req_valid = 4'h0;
      tick();
      check("stall_valid", 32'(rsp_valid), 1);
      reset = 1'b1;
      tick();
      check("midrst_valid", 32'(rsp_valid), 0);
      check("midrst_count", 32'(txn_count), 0);
      reset = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      #1 check("midrst_grant", 32'(req_ready), 32'h1);
      tick();
      check("midrst_id", 32'(rsp_id), 0);
      for (int i = 0; i < 16; i++) tick();
      check("wrap_wide", 32'(txn_count), 17);
      check("wrap_narrow", 32'(w_txn_count), 1);
      check("wrap_id", 32'(w_rsp_id), 0);
      req_valid = 4'h0;
      tick();
      check("drain_valid", 32'(rsp_valid), 0);
      check("drain_hold", 32'(rsp_data), 32'h11);
      check("drain_ready", 32'(req_ready), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
